lif_integrator: RTL and testbench

LIF_INTEGRATOR -- requirements
Module: lif_integrator

---
 rtl/lif_pkg.sv | 30 +++
 rtl/lif_sat_addsub.sv | 16 +
 rtl/lif_integrator.sv | 112 +++++++++++
 tb/tb_lif_integrator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types, saturation limits and default parameters for the LIF neuron.
package lif_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INTEG  = 2'd1,
        S_FIRE   = 2'd2,
        S_REFRAC = 2'd3
    } state_t;

    localparam logic signed [15:0] V_MAX = 16'sh7FFF;
    localparam logic signed [15:0] V_MIN = 16'sh8000;

    localparam logic signed [15:0] DEF_THRESHOLD     = 16'sd4096;
    localparam int unsigned        DEF_LEAK_SHIFT    = 4;
    localparam int unsigned        DEF_REFRAC_CYCLES = 3;
    localparam logic signed [15:0] DEF_V_RESET       = 16'sd0;

    // Clamp an 18-bit signed intermediate into the 16-bit membrane range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] s);
        if (s > 18'(V_MAX)) begin
            return V_MAX;
        end else if (s < 18'(V_MIN)) begin
            return V_MIN;
        end else begin
            return s[15:0];
        end
    endfunction

endpackage

// File: rtl/lif_sat_addsub.sv
// Combinational saturating datapath: y = sat16(a + b - c), 18-bit signed intermediate.
module lif_sat_addsub
    import lif_pkg::*;
(
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    input  logic signed [15:0] c,
    output logic signed [15:0] y
);

    logic signed [17:0] sum;

    assign sum = 18'(a) + 18'(b) - 18'(c);
    assign y   = sat16(sum);

endmodule

// File: rtl/lif_integrator.sv
// Leaky integrate-and-fire neuron: IDLE -> INTEG -> (FIRE -> REFRAC) -> IDLE.
// Defining LIF_SPIKE_COUNT_EN adds an 8-bit wrapping spike_count output.
module lif_integrator
    import lif_pkg::*;
#(
    parameter logic signed [15:0] THRESHOLD     = DEF_THRESHOLD,
    parameter int unsigned        LEAK_SHIFT    = DEF_LEAK_SHIFT,
    parameter int unsigned        REFRAC_CYCLES = DEF_REFRAC_CYCLES,
    parameter logic signed [15:0] V_RESET       = DEF_V_RESET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_current,
    output logic signed [15:0] v_mem,
    output logic               spike_out
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic [7:0]         spike_count
`endif
);

    localparam logic [7:0] REFRAC_LOAD = 8'(REFRAC_CYCLES);

    state_t             state;
    state_t             state_next;
    logic [7:0]         refrac_cnt;
    logic signed [15:0] x_reg;
    logic signed [15:0] leak;
    logic signed [15:0] v_next;
    logic               fire;

    assign leak = v_mem >>> LEAK_SHIFT;
    assign fire = (v_next >= THRESHOLD);

    lif_sat_addsub u_sat (
        .a (v_mem),
        .b (x_reg),
        .c (leak),
        .y (v_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_INTEG;
                end
            end
            S_INTEG:  state_next = fire ? S_FIRE : S_IDLE;
            S_FIRE:   state_next = (REFRAC_CYCLES > 0) ? S_REFRAC : S_IDLE;
            // Counter holds the remaining REFRAC cycles including the current one.
            S_REFRAC: if (refrac_cnt <= 8'd1) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_mem      <= '0;
            spike_out  <= 1'b0;
            refrac_cnt <= '0;
            x_reg      <= '0;
        end else begin
            spike_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg <= in_current;
                    end
                end
                S_INTEG: begin
                    v_mem     <= v_next;
                    spike_out <= fire;
                end
                S_FIRE: begin
                    v_mem      <= V_RESET;
                    refrac_cnt <= REFRAC_LOAD;
                end
                S_REFRAC: begin
                    if (refrac_cnt != 8'd0) begin
                        refrac_cnt <= refrac_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_count <= '0;
        end else if (state == S_INTEG && fire) begin
            spike_count <= spike_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lif_integrator.sv
// Self-checking bench for lif_integrator: vector table, corner sequences, random vs. model.
module tb_lif_integrator;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_current = '0;
    logic signed [15:0] v_mem;
    logic               spike_out;
`ifdef LIF_SPIKE_COUNT_EN
    logic [7:0]         spike_count;
`endif

    int checks   = 0;
    int failures = 0;

    lif_integrator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_current (in_current),
        .v_mem      (v_mem),
        .spike_out  (spike_out)
`ifdef LIF_SPIKE_COUNT_EN
        ,
        .spike_count(spike_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic signed [15:0] x;
        int                 exp_v;
        bit                 exp_spk;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, int'(in_ready), 1);
    endtask

    // One full transfer, checking latency, spike pulse and the refractory window.
    task automatic transact(input logic signed [15:0] x, input int exp_v,
                            input bit exp_spk, input string tag);
        int lows;
        wait_ready(tag);
        in_valid   = 1'b1;
        in_current = x;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        in_current = '0;
        check({tag, "_integ_ready"}, int'(in_ready), 0);
        @(negedge clk);
        check({tag, "_vmem"}, int'(v_mem), exp_v);
        check({tag, "_spike"}, int'(spike_out), int'(exp_spk));
        if (exp_spk) begin
            lows = 0;
            while (!in_ready && lows < 20) begin
                lows++;
                @(negedge clk);
                if (lows == 1) begin
                    check({tag, "_post_spike"}, int'(spike_out), 0);
                    check({tag, "_post_vmem"}, int'(v_mem), 0);
                end
            end
            check({tag, "_busy_cycles"}, lows, 4);
        end else begin
            check({tag, "_idle_ready"}, int'(in_ready), 1);
        end
    endtask

    function automatic int model_leak(input int v);
        return (v < 0) ? -((-v + 15) / 16) : v / 16;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        int model_v;
        int x;
        int nxt;
        int n;
        bit spk;

        tbl[0]  = '{16'sd1000,   1000,   1'b0};
        tbl[1]  = '{16'sd1000,   1938,   1'b0};
        tbl[2]  = '{16'sd5000,   6817,   1'b1};
        tbl[3]  = '{16'sd5000,   5000,   1'b1};
        tbl[4]  = '{-16'sd32768, -32768, 1'b0};
        tbl[5]  = '{-16'sd32768, -32768, 1'b0};
        tbl[6]  = '{16'sd32767,  2047,   1'b0};
        tbl[7]  = '{16'sd2100,   4020,   1'b0};
        tbl[8]  = '{16'sd327,    4096,   1'b1};
        tbl[9]  = '{-16'sd100,   -100,   1'b0};
        tbl[10] = '{16'sd0,      -93,    1'b0};

        // Reset state
        rst = 1'b1;
        #1;
        check("reset_vmem", int'(v_mem), 0);
        check("reset_spike", int'(spike_out), 0);
        check("reset_ready", int'(in_ready), 1);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            transact(tbl[i].x, tbl[i].exp_v, tbl[i].exp_spk, $sformatf("vec%0d", i));
        end

        // Reset asserted mid-FIRE
        do_reset();
        in_valid = 1'b1;
        in_current = 16'sd5000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("midfire_spike_before", int'(spike_out), 1);
        #2 rst = 1'b1;
        #1;
        check("midfire_rst_vmem", int'(v_mem), 0);
        check("midfire_rst_spike", int'(spike_out), 0);
        check("midfire_rst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midfire_release_ready", int'(in_ready), 1);

        // Reset asserted mid-REFRAC, then a fresh integration from zero
        @(negedge clk);
        in_valid = 1'b1;
        in_current = 16'sd5000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrefrac_busy", int'(in_ready), 0);
        #2 rst = 1'b1;
        #1 check("midrefrac_rst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrefrac_release_ready", int'(in_ready), 1);
        transact(16'sd1000, 1000, 1'b0, "after_rst");

        // Backpressure: held in_valid, second value taken on first IDLE after REFRAC
        do_reset();
        in_valid = 1'b1;
        in_current = 16'sd5000;
        @(posedge clk);
        @(negedge clk);
        in_current = 16'sd100;
        check("bp_integ_ready", int'(in_ready), 0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait_cycles", n, 5);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_accept", int'(in_ready), 0);
        @(negedge clk);
        check("bp_vmem", int'(v_mem), 100);
        check("bp_spike", int'(spike_out), 0);
        repeat (3) @(negedge clk);
        check("bp_vmem_hold", int'(v_mem), 100);
        check("bp_ready_hold", int'(in_ready), 1);

        // Randomized transfers against a transaction-level model
        do_reset();
        model_v = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) x = int'($urandom_range(0, 8000));
            else x = int'($urandom_range(0, 65535)) - 32768;
            nxt = clamp16(model_v + x - model_leak(model_v));
            spk = (nxt >= 4096);
            transact(16'(x), nxt, spk, $sformatf("rnd%0d", i));
            model_v = spk ? 0 : nxt;
        end

`ifdef LIF_SPIKE_COUNT_EN
        do_reset();
        check("cnt_reset", int'(spike_count), 0);
        for (int i = 0; i < 256; i++) begin
            transact(16'sd5000, 5000, 1'b1, "cnt");
            if (i == 0) check("cnt_one", int'(spike_count), 1);
            if (i == 254) check("cnt_255", int'(spike_count), 255);
        end
        check("cnt_wrap", int'(spike_count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
